// File: rtl/demux1to4_buf.sv
// Registered 1-to-4 demultiplexer with one single-entry holding register per channel.
// Define DEMUX_STATS_EN to add per-channel drain counters and an input stall counter.
module demux1to4_buf #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_bcast,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [3:0][N-1:0]   out_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [3:0][CW-1:0]  stat_cnt,
  output logic [CW-1:0]       stall_cnt
`endif
);

  logic [3:0][N-1:0] data_q, data_d;
  logic [3:0]        valid_q, valid_d;
  logic [3:0]        can_take;
  logic [3:0]        drain;
  logic [3:0]        wr_en;
  logic              in_xfer;

  // A slot can accept when it is empty or its consumer empties it this same cycle.
  assign can_take = ~valid_q | out_ready;
  assign drain    = valid_q & out_ready;
  assign in_ready = in_bcast ? (&can_take) : can_take[in_sel];
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    wr_en = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      wr_en[k] = in_xfer & (in_bcast | (in_sel == 2'(k)));
    end
  end

  // A write on a draining slot keeps it full with the new word, giving bubble-free flow.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~drain;
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) begin
        data_d[k]  = in_data;
        valid_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 4'b0000;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

`ifdef DEMUX_STATS_EN
  logic [3:0][CW-1:0] stat_q, stat_d;
  logic [CW-1:0]      stall_q, stall_d;

  // Counters wrap naturally at 2^CW.
  always_comb begin
    stat_d = stat_q;
    for (int k = 0; k < 4; k++) begin
      if (drain[k]) stat_d[k] = stat_q[k] + CW'(1);
    end
    stall_d = (in_valid & ~in_ready) ? stall_q + CW'(1) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q  <= '0;
      stall_q <= '0;
    end else begin
      stat_q  <= stat_d;
      stall_q <= stall_d;
    end
  end

  assign stat_cnt  = stat_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_demux1to4_buf.sv
// Directed self-checking bench for demux1to4_buf; stats checks compile in with DEMUX_STATS_EN.
module tb_demux1to4_buf;
  localparam int N  = 8;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_data;
  logic [1:0]        in_sel;
  logic              in_bcast;
  logic              in_valid;
  logic              in_ready;
  logic [3:0][N-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
`ifdef DEMUX_STATS_EN
  logic [3:0][CW-1:0] stat_cnt;
  logic [CW-1:0]      stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux1to4_buf #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
    ,
    .stat_cnt  (stat_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_sel = 2'd1; in_bcast = 1'b0;
    out_ready = 4'b1111;
    tick();
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_valid got=%b want=0000", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h want=00000000", out_data);
    end
    rst = 1'b0; in_valid = 1'b0; in_bcast = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_unicast();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    out_ready = 4'b1111; in_bcast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i); in_data = vals[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL uni_ready ch=%0d got=%b want=1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 4'(1 << i)) begin
        failures++; $display("FAIL uni_valid ch=%0d got=%b want=%b", i, out_valid, 4'(1 << i));
      end
      checks++;
      if (out_data[i] !== vals[i]) begin
        failures++; $display("FAIL uni_data ch=%0d got=%h want=%h", i, out_data[i], vals[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL uni_idle got=%b want=0000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011; in_bcast = 1'b0;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
    tick();
    checks++;
    if (out_valid !== 4'b0100 || out_data[2] !== 8'hA5) begin
      failures++; $display("FAIL bp_first got=%b/%h want=0100/a5", out_valid, out_data[2]);
    end
    in_sel = 2'd0; in_data = 8'h77;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_other_ready got=%b want=1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0101 || out_data[0] !== 8'h77 || out_data[2] !== 8'hA5) begin
      failures++; $display("FAIL bp_other got=%b/%h/%h want=0101/77/a5", out_valid, out_data[0], out_data[2]);
    end
    in_sel = 2'd2; in_data = 8'h5A;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_stall_ready got=%b want=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0100 || out_data[2] !== 8'hA5) begin
      failures++; $display("FAIL bp_hold got=%b/%h want=0100/a5", out_valid, out_data[2]);
    end
    out_ready = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready got=%b want=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100 || out_data[2] !== 8'h5A) begin
      failures++; $display("FAIL bp_second got=%b/%h want=0100/5a", out_valid, out_data[2]);
    end
    tick();
  endtask

  task automatic test_broadcast();
    out_ready = 4'b0111; in_bcast = 1'b0;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h3C;
    tick();
    in_bcast = 1'b1; in_sel = 2'd0; in_data = 8'hC3;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bc_stall_ready got=%b want=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b1000 || out_data[3] !== 8'h3C) begin
      failures++; $display("FAIL bc_hold got=%b/%h want=1000/3c", out_valid, out_data[3]);
    end
    out_ready = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bc_release_ready got=%b want=1", in_ready);
    end
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b1111 || out_data !== 32'hC3C3C3C3) begin
      failures++; $display("FAIL bc_all got=%b/%h want=1111/c3c3c3c3", out_valid, out_data);
    end
    out_ready = 4'b1111;
    tick();
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 32'hC3C3C3C3) begin
      failures++; $display("FAIL bc_drain got=%b/%h want=0000/c3c3c3c3", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 4'b0010; in_bcast = 1'b0; in_sel = 2'd1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h80 + i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_ready i=%0d got=%b want=1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== 8'(8'h80 + i)) begin
        failures++; $display("FAIL b2b_data i=%0d got=%b/%h want=1/%h", i, out_valid[1], out_data[1], 8'(8'h80 + i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL b2b_idle got=%b want=0000", out_valid);
    end
  endtask

  task automatic test_reset_midop();
    out_ready = 4'b0000; in_bcast = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_bcast = 1'b0;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
      failures++; $display("FAIL midop_reset got=%b/%h want=0000/00000000", out_valid, out_data);
    end
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats();
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 4'b0001; in_bcast = 1'b0; in_sel = 2'd0;
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (stat_cnt[0] !== 8'd1 || stall_cnt !== 8'd0) begin
      failures++; $display("FAIL stat_wrap got=%0d/%0d want=1/0", stat_cnt[0], stall_cnt);
    end
    out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 8'd2 || stat_cnt[0] !== 8'd1) begin
      failures++; $display("FAIL stall_cnt got=%0d/%0d want=2/1", stall_cnt, stat_cnt[0]);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (stall_cnt !== 8'd0 || stat_cnt !== 32'h0) begin
      failures++; $display("FAIL stat_reset got=%0d/%h want=0/0", stall_cnt, stat_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; out_ready = '0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_back_to_back();
    test_reset_midop();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux1to4_buf.md
Name: demux1to4_buf

Overview:
- Registered 1-to-4 demultiplexer: the distribution-side counterpart of the 4:1 selector.
- Accepts one N-bit word per cycle on a valid/ready input stream and steers it to one of four output channels by `in_sel`, or to all four in broadcast mode.
- Each channel holds the word in a single-entry output register until its consumer takes it.
- Sits between a shared producer and four independent consumers.

Parameters:
- `N`, default 8, data word width in bits.
- `CW`, default 8, width of per-channel statistics counters (used only with the optional feature).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input N: word to distribute.
- `in_sel` input 2: target channel index 0..3.
- `in_bcast` input 1: 1 = write the word to all four channels; `in_sel` is ignored.
- `in_valid` input 1: producer has a word.
- `in_ready` output 1: block can accept the word this cycle.
- `out_data` output [3:0][N-1:0]: per-channel held word, packed array, channel k in `out_data[k]`.
- `out_valid` output 4: bit k = channel k holds a word.
- `out_ready` input 4: bit k = consumer k takes the word this cycle.

Behaviour:
- Transfers:
  - Input transfer occurs when `in_valid && in_ready` at a rising edge.
  - Output transfer on channel k occurs when `out_valid[k] && out_ready[k]`.
- Reset (`rst=1` at an edge):
  - `out_valid=4'b0000` and `out_data` all zero.
  - Counters are zero.
  - Reset has priority over every transfer in the same cycle.
  - Any word held mid-operation is discarded.
- Per-channel slot state: EMPTY (`out_valid[k]=0`) or FULL (`out_valid[k]=1`).
- `can_take[k] = !out_valid[k] || out_ready[k]`: slot empty, or being drained this same cycle.
- `in_ready` is combinational, with no combinational dependence on `in_data`:
  - Unicast (`in_bcast=0`): `in_ready = can_take[in_sel]`.
  - Broadcast (`in_bcast=1`): `in_ready = &can_take`, i.e. all four slots must be able to accept.
- Write, unicast: on input transfer, `out_data[in_sel] <= in_data` and `out_valid[in_sel] <= 1`.
- Write, broadcast: on input transfer, all four slots load `in_data` and set valid.
- Drain: on an output transfer on k with no simultaneous write to k, `out_valid[k] <= 0`; `out_data[k]` holds its last value.
- Simultaneous drain and write on the same channel: the slot stays FULL with the new word. Throughput is one word per cycle per channel with no bubble.
- Latency: the word is visible on `out_data`/`out_valid` in the cycle after acceptance; there is no combinational path from input to output.
- Stability: while `out_valid[k]=1` and `out_ready[k]=0`, `out_data[k]` and `out_valid[k]` must not change.
- Independence: channels not targeted by the write are unaffected; a stalled channel never blocks unicast traffic to other channels.
- Input side: the producer holds `in_data`, `in_sel` and `in_bcast` stable while `in_valid=1` and `in_ready=0`. This is not checked by the block.
- `in_valid=0` with `in_ready=1` is legal; nothing is written.

Optional Feature:
- Macro: `DEMUX_STATS_EN`.
- Defined:
  - Adds output port `stat_cnt` [3:0][CW-1:0]. `stat_cnt[k]` increments by 1 on each output transfer on channel k.
  - Adds output port `stall_cnt` [CW-1:0]. It increments on each cycle with `in_valid=1` and `in_ready=0`.
  - All counters wrap modulo 2^CW (255→0 at CW=8), are cleared by `rst`, and update in the same edge as the transfer.
- Not defined: the ports and logic are absent; the datapath behaves identically.

Test Plan:
- Reset: assert `rst` for 2 cycles with `in_valid=1`, `out_ready=4'b1111` → `out_valid=0000`, `out_data` all 0, no write during reset; `in_ready=1` after release with `in_bcast=0`.
- Unicast routing, N=8, `out_ready=1111`:
  - Stimulus: 0x11 to sel 0, 0x22 to sel 1, 0x33 to sel 2, 0x44 to sel 3 on consecutive cycles.
  - Response: each word appears on its channel exactly one cycle after acceptance with a single-cycle valid pulse; other channels show no valid.
- Backpressure: `out_ready[2]=0`, send 0xA5 to sel 2, then 0x5A to sel 2.
  - Second word sees `in_ready=0`; `out_data[2]` stays 0xA5.
  - Raising `out_ready[2]` accepts 0x5A in that same cycle; `out_data[2]` becomes 0x5A next cycle.
  - Meanwhile 0x77 to sel 0 is accepted.
- Broadcast: channel 3 FULL and stalled, send 0xC3 with `in_bcast=1` → `in_ready=0`.
  - Release channel 3 → word accepted in that cycle.
  - Next cycle `out_valid=1111` with all `out_data=0xC3`.
- Full throughput: 8 back-to-back words to sel 1 with `out_ready[1]=1` → `in_ready` stays 1, `out_valid[1]` is continuously 1, and data appears in order.
- Stats, `DEMUX_STATS_EN` with CW=8: 257 transfers on channel 0 → `stat_cnt[0]=1`. Two stalled cycles → `stall_cnt=2`. `rst` clears both counters.
